// File: rtl/avalon_regbank_pkg.sv
// Shared address offsets, default ID and byte-lane mask helper for avalon_register_bank.
package avalon_regbank_pkg;

  localparam int ADDR_ID         = 0;
  localparam int ADDR_COMMIT_OFS = 1;
  localparam int ADDR_STATUS_OFS = 2;
  localparam int ADDR_IRQ_OFS    = 3;
  localparam int ADDR_MASK_OFS   = 4;

  localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA9E0_0001;

  function automatic logic [7:0] lane_mask(input logic en);
    lane_mask = en ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/regbank_cell.sv
// One shadow/active register pair: byte-masked shadow write with a write pulse,
// and an atomic shadow-to-active load on commit.
module regbank_cell #(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_mask,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit,
  output logic [DATA_W-1:0] shadow,
  output logic [DATA_W-1:0] active,
  output logic              wr_pulse
);

  // shadow update, commit load and write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow   <= RESET_VALUE;
      active   <= RESET_VALUE;
      wr_pulse <= 1'b0;
    end else begin
      wr_pulse <= wr_en;
      if (wr_en) begin
        shadow <= (shadow & ~wr_mask) | (wr_data & wr_mask);
      end
      if (commit) begin
        active <= shadow;
      end
    end
  end

endmodule

// File: rtl/avalon_register_bank.sv
// Avalon-MM register bank with shadowed control registers and atomic commit.
// Define STATUS_IRQ_EN to add status change flags, an IRQ mask register and irq.
module avalon_register_bank
  import avalon_regbank_pkg::*;
#(
  parameter int                NUM_REGS    = 4,
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 8,
  parameter logic [DATA_W-1:0] ID_VALUE    = DATA_W'(DEFAULT_ID_VALUE),
  parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       chipselect,
  input  logic                       read,
  input  logic                       write,
  input  logic [ADDR_W-1:0]          address,
  input  logic [DATA_W/8-1:0]        byteenable,
  input  logic [DATA_W-1:0]          writedata,
  output logic [DATA_W-1:0]          readdata,
  output logic                       readdatavalid,
  output logic [NUM_REGS*DATA_W-1:0] q,
  output logic [NUM_REGS-1:0]        wr_pulse,
  output logic                       commit_pulse,
  input  logic [DATA_W-1:0]          status_in,
  output logic                       irq
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'(ADDR_ID);
  localparam logic [ADDR_W-1:0] A_COMMIT = ADDR_W'(NUM_REGS + ADDR_COMMIT_OFS);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(NUM_REGS + ADDR_STATUS_OFS);
`ifdef STATUS_IRQ_EN
  localparam logic [ADDR_W-1:0] A_IRQ    = ADDR_W'(NUM_REGS + ADDR_IRQ_OFS);
  localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(NUM_REGS + ADDR_MASK_OFS);
`endif

  logic                wr_acc_s;
  logic                rd_acc_s;
  logic                commit_s;
  logic                shadow_wr_s;
  logic [DATA_W-1:0]   wr_mask_s;
  logic [NUM_REGS-1:0] shadow_sel_s;
  logic [DATA_W-1:0]   shadow_s [NUM_REGS];
  logic [DATA_W-1:0]   shadow_rd_s;
  logic [DATA_W-1:0]   rd_data_s;
  logic                pending_r;

  // A simultaneous read+write is treated as a write only.
  assign wr_acc_s    = chipselect & write;
  assign rd_acc_s    = chipselect & read & ~write;
  assign commit_s    = wr_acc_s & (address == A_COMMIT) & writedata[0];
  assign shadow_wr_s = wr_acc_s & (|shadow_sel_s);

  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign wr_mask_s[b*8 +: 8] = lane_mask(byteenable[b]);
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_cell
    assign shadow_sel_s[k] = (address == ADDR_W'(k + 1));

    regbank_cell #(
      .DATA_W      (DATA_W),
      .RESET_VALUE (RESET_VALUE)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_acc_s & shadow_sel_s[k]),
      .wr_mask  (wr_mask_s),
      .wr_data  (writedata),
      .commit   (commit_s),
      .shadow   (shadow_s[k]),
      .active   (q[k*DATA_W +: DATA_W]),
      .wr_pulse (wr_pulse[k])
    );
  end

  // pending tracks shadow writes not yet committed; commit strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r    <= 1'b0;
      commit_pulse <= 1'b0;
    end else begin
      commit_pulse <= commit_s;
      if (commit_s) begin
        pending_r <= 1'b0;
      end else if (shadow_wr_s) begin
        pending_r <= 1'b1;
      end
    end
  end

`ifdef STATUS_IRQ_EN
  logic [DATA_W-1:0] status_prev_r;
  logic [DATA_W-1:0] flags_r;
  logic [DATA_W-1:0] mask_r;
  logic [DATA_W-1:0] clr_s;
  logic              irq_r;

  assign clr_s = (wr_acc_s && (address == A_IRQ)) ? (writedata & wr_mask_s) : '0;

  // change detection: a new change in the same cycle overrides a W1C clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_prev_r <= '0;
      flags_r       <= '0;
      mask_r        <= '0;
      irq_r         <= 1'b0;
    end else begin
      status_prev_r <= status_in;
      flags_r       <= (flags_r & ~clr_s) | (status_in ^ status_prev_r);
      if (wr_acc_s && (address == A_MASK)) begin
        mask_r <= (mask_r & ~wr_mask_s) | (writedata & wr_mask_s);
      end
      irq_r <= |(flags_r & mask_r);
    end
  end

  assign irq = irq_r;
`else
  assign irq = 1'b0;
`endif

  // read data mux; shadows are OR-combined by one-hot select
  always_comb begin
    shadow_rd_s = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      shadow_rd_s = shadow_rd_s | (shadow_sel_s[k] ? shadow_s[k] : '0);
    end
    case (address)
      A_ID:     rd_data_s = ID_VALUE;
      A_COMMIT: rd_data_s = {{(DATA_W-1){1'b0}}, pending_r};
      A_STATUS: rd_data_s = status_in;
`ifdef STATUS_IRQ_EN
      A_IRQ:    rd_data_s = flags_r;
      A_MASK:   rd_data_s = mask_r;
`endif
      default:  rd_data_s = shadow_rd_s;
    endcase
  end

  // single-cycle read pipeline; readdata holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= rd_acc_s;
      if (rd_acc_s) begin
        readdata <= rd_data_s;
      end
    end
  end

endmodule

// File: tb/tb_avalon_register_bank.sv
// Self-checking bench for avalon_register_bank: read scoreboard plus per-feature tasks.
module tb_avalon_register_bank;

  localparam int NUM_REGS = 4;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 8;
  localparam logic [31:0] ID       = 32'hA9E0_0001;
  localparam logic [7:0]  A_COMMIT = 8'd5;
  localparam logic [7:0]  A_STATUS = 8'd6;
  localparam logic [7:0]  A_IRQ    = 8'd7;
  localparam logic [7:0]  A_MASK   = 8'd8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           chipselect = 1'b0;
  logic           read = 1'b0;
  logic           write = 1'b0;
  logic [7:0]     address = 8'd0;
  logic [3:0]     byteenable = 4'd0;
  logic [31:0]    writedata = 32'd0;
  logic [31:0]    status_in = 32'hC0FF_EE00;
  logic [31:0]    readdata;
  logic           readdatavalid;
  logic [127:0]   q;
  logic [3:0]     wr_pulse;
  logic           commit_pulse;
  logic           irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  avalon_register_bank #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .address       (address),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .q             (q),
    .wr_pulse      (wr_pulse),
    .commit_pulse  (commit_pulse),
    .status_in     (status_in),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // scoreboard: every readdatavalid pulse must match the oldest expected read
  always @(negedge clk) begin : monitor
    logic [31:0] e_v;
    if (readdatavalid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: readdatavalid with no read pending, readdata=%h", readdata);
      end else begin
        e_v = exp_q.pop_front();
        if (readdata !== e_v) begin
          n_fail++;
          $display("FAIL rd_data: got %h expected %h at t=%0t", readdata, e_v, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = a; writedata = d; byteenable = be;
    cycle();
    drive_idle();
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] e);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    exp_q.push_back(e);
    cycle();
    drive_idle();
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) cycle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rd_timeout: %0d reads without readdatavalid, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (readdata !== 32'd0 || readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rd: readdata=%h rdv=%b expected 0/0", readdata, readdatavalid);
    end
    n_checks++;
    if (q !== 128'd0 || wr_pulse !== 4'd0) begin
      n_fail++; $display("FAIL reset_q: q=%h wr_pulse=%b expected 0", q, wr_pulse);
    end
    n_checks++;
    if (commit_pulse !== 1'b0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulse: commit_pulse=%b irq=%b expected 0", commit_pulse, irq);
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_id_read();
    do_read(8'd0, ID);
    do_read(8'd1, 32'd0);
    do_read(A_COMMIT, 32'd0);
    drain();
    n_checks++;
    if (q !== 128'd0) begin
      n_fail++; $display("FAIL id_q: q=%h expected 0", q);
    end
  endtask

  task automatic test_shadow_write();
    do_write(8'd2, 32'h1234_5678, 4'b1111);
    n_checks++;
    if (wr_pulse !== 4'b0010) begin
      n_fail++; $display("FAIL wr_pulse_set: got %b expected 0010", wr_pulse);
    end
    n_checks++;
    if (q !== 128'd0) begin
      n_fail++; $display("FAIL q_before_commit: got %h expected 0", q);
    end
    cycle();
    n_checks++;
    if (wr_pulse !== 4'b0000) begin
      n_fail++; $display("FAIL wr_pulse_clear: got %b expected 0000", wr_pulse);
    end
    do_read(8'd2, 32'h1234_5678);
    do_read(A_COMMIT, 32'd1);
    drain();
  endtask

  task automatic test_commit();
    do_write(A_COMMIT, 32'd1, 4'b1111);
    n_checks++;
    if (commit_pulse !== 1'b1) begin
      n_fail++; $display("FAIL commit_pulse: got %b expected 1", commit_pulse);
    end
    n_checks++;
    if (q !== 128'h0000_0000_0000_0000_1234_5678_0000_0000) begin
      n_fail++; $display("FAIL commit_q: got %h expected reg1=12345678", q);
    end
    cycle();
    n_checks++;
    if (commit_pulse !== 1'b0) begin
      n_fail++; $display("FAIL commit_pulse_len: got %b expected 0", commit_pulse);
    end
    do_read(A_COMMIT, 32'd0);
    drain();
  endtask

  task automatic test_commit_noop();
    do_write(8'd1, 32'h0000_00AA, 4'b1111);
    do_write(A_COMMIT, 32'h0000_0002, 4'b1111);
    n_checks++;
    if (commit_pulse !== 1'b0 || q !== 128'h0000_0000_0000_0000_1234_5678_0000_0000) begin
      n_fail++; $display("FAIL commit_bit0_zero: pulse=%b q=%h expected 0 and unchanged", commit_pulse, q);
    end
    do_read(A_COMMIT, 32'd1);
    drain();
    do_write(A_COMMIT, 32'd1, 4'b1111);
    do_write(A_COMMIT, 32'd1, 4'b1111);
    n_checks++;
    if (commit_pulse !== 1'b1 || q !== 128'h0000_0000_0000_0000_1234_5678_0000_00AA) begin
      n_fail++; $display("FAIL commit_no_pending: pulse=%b q=%h expected 1, reg0=AA reg1=12345678", commit_pulse, q);
    end
  endtask

  task automatic test_byte_enable();
    do_write(8'd2, 32'hFFFF_FFFF, 4'b1111);
    do_write(8'd2, 32'h0000_00AB, 4'b0001);
    do_read(8'd2, 32'hFFFF_FFAB);
    do_write(8'd2, 32'h11CD_EF22, 4'b0110);
    do_read(8'd2, 32'hFFCD_EFAB);
    drain();
  endtask

  task automatic test_ro_write();
    do_write(8'd0, 32'd0, 4'b1111);
    n_checks++;
    if (wr_pulse !== 4'b0000) begin
      n_fail++; $display("FAIL ro_wr_pulse: got %b expected 0000", wr_pulse);
    end
    do_write(A_STATUS, 32'd0, 4'b1111);
    do_read(8'd0, ID);
    cycle();
    n_checks++;
    if (readdatavalid !== 1'b0 || readdata !== ID) begin
      n_fail++; $display("FAIL rd_hold: rdv=%b readdata=%h expected 0/%h", readdatavalid, readdata, ID);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  addrs [4];
    logic [31:0] exps  [4];
    addrs = '{8'd0, 8'd1, A_STATUS, 8'd63};
    exps  = '{ID, 32'd5, 32'hC0FF_EE00, 32'd0};
    chipselect = 1'b1; read = 1'b1; write = 1'b1;
    address = 8'd1; writedata = 32'd5; byteenable = 4'b1111;
    cycle();
    n_checks++;
    if (readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL rw_no_rdv: got %b expected 0", readdatavalid);
    end
    for (int i = 0; i < 4; i++) begin
      write = 1'b0; read = 1'b1; address = addrs[i];
      exp_q.push_back(exps[i]);
      cycle();
      n_checks++;
      if (readdatavalid !== 1'b1) begin
        n_fail++; $display("FAIL b2b_rdv[%0d]: got %b expected 1", i, readdatavalid);
      end
    end
    drive_idle();
    drain();
  endtask

`ifdef STATUS_IRQ_EN
  task automatic test_irq();
    do_write(A_IRQ, 32'hFFFF_FFFF, 4'b1111);
    do_write(A_MASK, 32'd1, 4'b1111);
    cycle();
    cycle();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_idle: got %b expected 0", irq);
    end
    status_in[0] = ~status_in[0];
    for (int i = 0; i < 2 && irq !== 1'b1; i++) cycle();
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_rise: got %b expected 1", irq);
    end
    do_read(A_MASK, 32'd1);
    do_read(A_IRQ, 32'd1);
    drain();
    do_write(A_IRQ, 32'd1, 4'b1111);
    cycle();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_w1c: got %b expected 0", irq);
    end
  endtask
`else
  task automatic test_irq();
    do_write(A_MASK, 32'd1, 4'b1111);
    status_in[0] = ~status_in[0];
    cycle();
    cycle();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_tied: got %b expected 0", irq);
    end
    do_read(A_IRQ, 32'd0);
    do_read(A_MASK, 32'd0);
    drain();
  endtask
`endif

  task automatic test_reset_mid_read();
    do_write(8'd4, 32'hDEAD_BEEF, 4'b1111);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 8'd0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (readdatavalid !== 1'b0 || q !== 128'd0) begin
      n_fail++; $display("FAIL rst_async: rdv=%b q=%h expected 0/0", readdatavalid, q);
    end
    drive_idle();
    cycle();
    n_checks++;
    if (readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL rst_discard: rdv=%b expected 0", readdatavalid);
    end
    #2;
    rst = 1'b0;
    cycle();
    do_read(8'd4, 32'd0);
    do_read(A_COMMIT, 32'd0);
    drain();
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_shadow_write();
    test_commit();
    test_commit_noop();
    test_byte_enable();
    test_ro_write();
    test_back_to_back();
    test_irq();
    test_reset_mid_read();
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_register_bank.md
Name: avalon_register_bank

Overview:
- Parametrised Avalon-MM slave register bank; successor to the fixed three-register interface.
- NUM_REGS control registers of DATA_W bits, written through shadow copies and applied atomically to exported outputs on a COMMIT write.
- Adds byte enables, pipelined read with readdatavalid, per-register write pulses and a read-only status register.
- Sits between the Nios II Avalon fabric and PL logic that needs glitch-free multi-register updates.

Parameters:
- NUM_REGS, 4, number of RW control registers (1..16).
- DATA_W, 32, register and bus width; multiple of 8.
- ADDR_W, 8, word-address width; NUM_REGS+4 <= 2**ADDR_W.
- ID_VALUE, 32'hA9E0_0001, constant returned at address 0.
- RESET_VALUE, 0, reset value of every shadow and active register.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- chipselect  in  1  slave select
- read  in  1  read request
- write  in  1  write request
- address  in  ADDR_W  word address
- byteenable  in  DATA_W/8  write byte lanes
- writedata  in  DATA_W  write data
- readdata  out  DATA_W  read data, registered
- readdatavalid  out  1  one-cycle pulse marking valid readdata
- q  out  NUM_REGS*DATA_W  active registers, reg k at bits [k*DATA_W +: DATA_W]
- wr_pulse  out  NUM_REGS  one-cycle pulse: shadow k written
- commit_pulse  out  1  one-cycle pulse: active registers updated
- status_in  in  DATA_W  live status from PL
- irq  out  1  interrupt (STATUS_IRQ_EN only; tied 0 otherwise)

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - shadow and active registers = RESET_VALUE
  - readdata = 0
  - readdatavalid, wr_pulse, commit_pulse, irq = 0
  - pending = 0
- Address map (word addresses):
  - 0: ID, RO.
  - 1..NUM_REGS: shadow k-1, RW.
  - NUM_REGS+1: COMMIT. Write with writedata[0]=1 copies all shadows to active. Read returns {0,pending}.
  - NUM_REGS+2: STATUS, RO, status_in sampled on the read cycle.
  - NUM_REGS+3: IRQ, used only with the feature; otherwise reads 0.
  - Unmapped: read returns 0, write ignored.
- Write:
  - Accepted when chipselect&write.
  - Each byte lane is updated only where its byteenable bit is 1.
  - Writes take effect at the next clk edge.
  - A shadow write sets wr_pulse[k] for 1 cycle and sets pending.
  - Writes to RO addresses are dropped without error.
- Commit:
  - Active registers load all shadows on the edge after the COMMIT write.
  - commit_pulse asserts in the same cycle the new q is visible.
  - pending clears.
  - A COMMIT write with bit0=0 has no effect.
  - Commit with pending=0 still pulses commit_pulse; q is unchanged in value.
- Read:
  - Accepted when chipselect&read&!write.
  - Fixed latency 1: readdata and readdatavalid are registered on the next edge.
  - readdata holds its last value when readdatavalid=0.
  - Back-to-back reads are supported every cycle.
  - Shadow reads return the shadow value, not the active value.
  - A read in the cycle after a write to the same address returns the new value.
- Read and write asserted together: the write is performed, the read is ignored, and no readdatavalid is produced.
- No waitrequest; the slave is always ready.
- Reset mid-operation: any in-flight read is discarded (readdatavalid=0) and pending shadow data is lost.

Optional Feature:
- Macro: STATUS_IRQ_EN.
- With the macro:
  - IRQ register at NUM_REGS+3: bits[DATA_W-1:0] are sticky change flags; a flag sets when a status_in bit differs from its previous-cycle value.
  - Writing 1 to a bit clears that flag (W1C).
  - Set wins over clear in the same cycle.
  - irq = |(flags & mask), where mask is an RW register at NUM_REGS+4 with reset value 0. This requires NUM_REGS+5 <= 2**ADDR_W.
  - irq is registered; it rises 1 cycle after a flag sets.
- Without the macro: irq=0, both addresses are unmapped, and no status history flops exist.

Decomposition:
- Package avalon_regbank_pkg holds:
  - address-offset constants ADDR_ID, ADDR_COMMIT_OFS, ADDR_STATUS_OFS, ADDR_IRQ_OFS, ADDR_MASK_OFS;
  - the default ID_VALUE;
  - a byte-mask helper function.
- Sub-module regbank_cell: one DATA_W shadow+active register pair with byteenable write, wr_pulse and commit load. Instantiated NUM_REGS times in a generate loop.

Test Plan:
- Reset, then read addr 0 → readdatavalid 1 cycle later, readdata=32'hA9E0_0001. Read addr 1 → 0 and q=0.
- Write addr 2 = 32'h1234_5678 with be=4'b1111 → wr_pulse[1] for 1 cycle, q unchanged. Read addr 2 → 32'h1234_5678. Read COMMIT → 1.
- Write COMMIT=1 → next cycle commit_pulse=1 and q[63:32]=32'h1234_5678. Read COMMIT → 0.
- With shadow 1=32'hFFFF_FFFF, write 32'h0000_00AB with be=4'b0001 → shadow reads 32'hFFFF_FFAB.
- Drive read and write together to addr 1 (wd=5), then read every cycle for 4 cycles at addresses 0,1,NUM_REGS+2,63:
  - the first cycle gives no readdatavalid and shadow=5;
  - 4 consecutive readdatavalid pulses return ID, 5, status_in, 0.
- STATUS_IRQ_EN: set mask=1, toggle status_in[0] → irq=1 within 2 cycles. Write IRQ=1 → irq=0. Assert rst mid-read → readdatavalid=0 and q=0 immediately.
